// File: rtl/slp_weight_update_seq.sv
// Sequential perceptron weight-update engine: w[i] += (in[i]*error) >>> shift,
// LANES weights per cycle, with saturate/wrap selection and overflow reporting.
module slp_weight_update_seq #(
  parameter int N_IN    = 8,
  parameter int LANES   = 2,
  parameter int I_PREC  = 8,
  parameter int P_PREC  = 8,
  parameter int W_PREC  = 16,
  parameter int SHIFT_W = 4,
  parameter int SAT     = 1,
  localparam int IDX_W  = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     upd_valid,
  output logic                     upd_ready,
  input  logic [N_IN*I_PREC-1:0]   upd_in,
  input  logic [P_PREC-1:0]        upd_error,
  input  logic [SHIFT_W-1:0]       upd_shift,
  output logic                     done,
  output logic                     busy,
  input  logic                     wr_en,
  input  logic [IDX_W-1:0]         wr_idx,
  input  logic [W_PREC-1:0]        wr_data,
  input  logic [IDX_W-1:0]         rd_idx,
  output logic [W_PREC-1:0]        rd_data,
  output logic                     ovf,
  output logic                     ovf_sticky,
  input  logic                     clr_ovf
);

  localparam int K  = (N_IN + LANES - 1) / LANES;
  localparam int GW = (K > 1) ? $clog2(K) : 1;
  localparam int PW = I_PREC + P_PREC;
  localparam int SW = ((W_PREC > PW) ? W_PREC : PW) + 1;

  localparam logic [GW-1:0]            LAST_G = GW'(K - 1);
  localparam logic [IDX_W:0]           N_IN_V = (IDX_W + 1)'(N_IN);
  localparam logic signed [W_PREC-1:0] W_MAX  = {1'b0, {(W_PREC - 1){1'b1}}};
  localparam logic signed [W_PREC-1:0] W_MIN  = {1'b1, {(W_PREC - 1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t                    state, state_nxt;
  logic [GW-1:0]             grp;
  logic signed [W_PREC-1:0]  w      [N_IN];
  logic signed [I_PREC-1:0]  in_q   [N_IN];
  logic signed [P_PREC-1:0]  err_q;
  logic [SHIFT_W-1:0]        shift_q;
  logic                      accept;

  int                        lane_pos   [LANES];
  logic [IDX_W-1:0]          lane_idx   [LANES];
  logic signed [I_PREC-1:0]  lane_in    [LANES];
  logic signed [W_PREC-1:0]  lane_w     [LANES];
  logic signed [PW-1:0]      lane_prod  [LANES];
  logic signed [PW-1:0]      lane_delta [LANES];
  logic signed [SW-1:0]      lane_sum   [LANES];
  logic signed [W_PREC-1:0]  lane_new   [LANES];
  logic [LANES-1:0]          lane_act, lane_of, lane_ovf;

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    upd_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      S_IDLE: begin
        upd_ready = 1'b1;
        if (upd_valid) state_nxt = S_CALC;
      end
      S_CALC: begin
        busy = 1'b1;
        if (grp == LAST_G) state_nxt = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign accept = upd_valid && (state == S_IDLE);

  // Lanes past N_IN in a partial last group read zero and never write.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_pos[l]   = int'(grp) * LANES + l;
      lane_idx[l]   = lane_pos[l][IDX_W-1:0];
      lane_act[l]   = (state == S_CALC) && (lane_pos[l] < N_IN);
      lane_in[l]    = (lane_pos[l] < N_IN) ? in_q[lane_idx[l]] : '0;
      lane_w[l]     = (lane_pos[l] < N_IN) ? w[lane_idx[l]] : '0;
      lane_prod[l]  = lane_in[l] * err_q;
      lane_delta[l] = lane_prod[l] >>> shift_q;
      lane_sum[l]   = {{(SW - W_PREC){lane_w[l][W_PREC-1]}}, lane_w[l]}
                    + {{(SW - PW){lane_delta[l][PW-1]}}, lane_delta[l]};
      // In range exactly when the bits from the weight sign upward all agree.
      lane_of[l]    = !((&lane_sum[l][SW-1:W_PREC-1]) || (~|lane_sum[l][SW-1:W_PREC-1]));
      lane_ovf[l]   = lane_act[l] && lane_of[l];
      lane_new[l]   = lane_sum[l][W_PREC-1:0];
      if ((SAT != 0) && lane_of[l]) lane_new[l] = lane_sum[l][SW-1] ? W_MIN : W_MAX;
    end
  end

  // NOTE: state uses non-blocking assignments only, so every register here
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      grp        <= '0;
      ovf        <= 1'b0;
      ovf_sticky <= 1'b0;
      rd_data    <= '0;
      for (int i = 0; i < N_IN; i++) w[i] <= '0;
    end else begin
      state   <= state_nxt;
      ovf     <= |lane_ovf;
      rd_data <= ({1'b0, rd_idx} < N_IN_V) ? w[rd_idx] : '0;
      if (ovf) ovf_sticky <= 1'b1;
      else if (clr_ovf) ovf_sticky <= 1'b0;
      if (state == S_CALC) grp <= (grp == LAST_G) ? '0 : grp + 1'b1;
      if ((state == S_IDLE) && wr_en && ({1'b0, wr_idx} < N_IN_V)) w[wr_idx] <= wr_data;
      for (int l = 0; l < LANES; l++) begin
        if (lane_act[l]) w[lane_idx[l]] <= lane_new[l];
      end
    end
  end

  // NOTE: the operand latches are deliberately left out of reset; they are
  // always loaded on accept before CALC reads them, unlike the weights, which
  // must visibly return to zero.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < N_IN; i++) in_q[i] <= upd_in[i*I_PREC +: I_PREC];
      err_q   <= upd_error;
      shift_q <= upd_shift;
    end
  end

endmodule

// File: tb/tb_slp_weight_update_seq.sv
// Self-checking bench: an 8-input saturating engine and a 5-input wrapping engine,
// checked with constant tables, hand sequences and a floor-division reference model.
module tb_slp_weight_update_seq;

  localparam int NT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        upd_valid [NT];
  logic        upd_ready [NT];
  logic [63:0] upd_in_a;
  logic [39:0] upd_in_b;
  logic [7:0]  upd_error [NT];
  logic [3:0]  upd_shift [NT];
  logic        done [NT];
  logic        busy [NT];
  logic        wr_en [NT];
  logic [2:0]  wr_idx [NT];
  logic [15:0] wr_data [NT];
  logic [2:0]  rd_idx [NT];
  logic [15:0] rd_data [NT];
  logic        ovf [NT];
  logic        ovf_sticky [NT];
  logic        clr_ovf [NT];

  int n_checks = 0;
  int n_errors = 0;

  longint mw [NT][8];
  bit     msticky [NT];

  always #5 clk = ~clk;

  slp_weight_update_seq #(.N_IN(8), .LANES(2), .I_PREC(8), .P_PREC(8), .W_PREC(16),
                          .SHIFT_W(4), .SAT(1)) dut (
    .clk(clk), .reset(reset), .upd_valid(upd_valid[0]), .upd_ready(upd_ready[0]),
    .upd_in(upd_in_a), .upd_error(upd_error[0]), .upd_shift(upd_shift[0]),
    .done(done[0]), .busy(busy[0]), .wr_en(wr_en[0]), .wr_idx(wr_idx[0]),
    .wr_data(wr_data[0]), .rd_idx(rd_idx[0]), .rd_data(rd_data[0]), .ovf(ovf[0]),
    .ovf_sticky(ovf_sticky[0]), .clr_ovf(clr_ovf[0]));

  slp_weight_update_seq #(.N_IN(5), .LANES(2), .I_PREC(8), .P_PREC(8), .W_PREC(16),
                          .SHIFT_W(4), .SAT(0)) dut_b (
    .clk(clk), .reset(reset), .upd_valid(upd_valid[1]), .upd_ready(upd_ready[1]),
    .upd_in(upd_in_b), .upd_error(upd_error[1]), .upd_shift(upd_shift[1]),
    .done(done[1]), .busy(busy[1]), .wr_en(wr_en[1]), .wr_idx(wr_idx[1]),
    .wr_data(wr_data[1]), .rd_idx(rd_idx[1]), .rd_data(rd_data[1]), .ovf(ovf[1]),
    .ovf_sticky(ovf_sticky[1]), .clr_ovf(clr_ovf[1]));

  typedef struct {
    int dut;
    int w0;
    int x0;
    int err;
    int sh;
    int exp_w0;
    bit exp_ovf;
  } vec_t;

  function automatic int n_of(input int d);
    return (d == 0) ? 8 : 5;
  endfunction

  function automatic bit sat_of(input int d);
    return d == 0;
  endfunction

  function automatic longint floor_shr(input longint p, input int sh);
    longint div = longint'(1) << sh;
    longint q   = p / div;
    if (p < 0 && q * div != p) q = q - 1;
    return q;
  endfunction

  function automatic longint elem(input logic [63:0] v, input int i);
    logic [7:0] b = v[i*8 +: 8];
    return longint'($signed(b));
  endfunction

  task automatic model_update(input int d, input logic [63:0] vin, input int err,
                              input int sh, output bit any_ovf);
    any_ovf = 1'b0;
    for (int i = 0; i < n_of(d); i++) begin
      longint s = mw[d][i] + floor_shr(elem(vin, i) * err, sh);
      if (s > 32767 || s < -32768) begin
        any_ovf = 1'b1;
        if (sat_of(d)) s = (s > 0) ? 32767 : -32768;
        else begin
          s = s & 64'hFFFF;
          if (s > 32767) s = s - 65536;
        end
      end
      mw[d][i] = s;
    end
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    for (int d = 0; d < NT; d++) begin
      msticky[d] = 1'b0;
      for (int i = 0; i < 8; i++) mw[d][i] = 0;
    end
  endtask

  task automatic read_w(input int d, input int idx, output longint v);
    rd_idx[d] = 3'(idx);
    tick();
    v = longint'($signed(rd_data[d]));
  endtask

  task automatic check_all(input int d, input string tag);
    longint v;
    for (int i = 0; i < 8; i++) begin
      read_w(d, i, v);
      check($sformatf("%s dut%0d w[%0d]", tag, d, i), v, (i < n_of(d)) ? mw[d][i] : 0);
    end
  endtask

  task automatic load(input int d, input int idx, input int val);
    wr_en[d]   = 1'b1;
    wr_idx[d]  = 3'(idx);
    wr_data[d] = 16'(val);
    tick();
    wr_en[d] = 1'b0;
    if (idx < n_of(d)) mw[d][idx] = longint'($signed(16'(val)));
  endtask

  task automatic set_in(input int d, input logic [63:0] vin);
    if (d == 0) upd_in_a = vin;
    else upd_in_b = vin[39:0];
  endtask

  task automatic run_upd(input int d, input logic [63:0] vin, input int err, input int sh,
                         input bit do_wr, input int wi, input int wd, input bit clr_mode,
                         output bit ovf_seen);
    int lat;
    bit clr_drop;
    bit exp_ovf;
    int k = (n_of(d) + 1) / 2;
    set_in(d, vin);
    upd_error[d] = 8'(err);
    upd_shift[d] = 4'(sh);
    upd_valid[d] = 1'b1;
    if (do_wr) begin
      wr_en[d]   = 1'b1;
      wr_idx[d]  = 3'(wi);
      wr_data[d] = 16'(wd);
    end
    if (clr_mode) clr_ovf[d] = 1'b1;
    check($sformatf("dut%0d ready before accept", d), upd_ready[d], 1);
    tick();
    upd_valid[d] = 1'b0;
    wr_en[d]     = 1'b0;
    if (do_wr && wi < n_of(d)) mw[d][wi] = longint'($signed(16'(wd)));
    set_in(d, 64'hA5A5_A5A5_A5A5_A5A5);
    upd_error[d] = 8'h81;
    upd_shift[d] = 4'hF;
    lat      = 1;
    ovf_seen = 1'b0;
    clr_drop = 1'b0;
    forever begin
      if (ovf[d]) begin
        ovf_seen = 1'b1;
        clr_drop = 1'b1;
      end
      if (clr_mode && lat == 2)
        check($sformatf("dut%0d sticky cleared by clr", d), ovf_sticky[d], 0);
      if (done[d] || lat > 40) break;
      tick();
      lat++;
      if (clr_drop) clr_ovf[d] = 1'b0;
    end
    check($sformatf("dut%0d done latency", d), lat, k + 1);
    tick();
    clr_ovf[d] = 1'b0;
    check($sformatf("dut%0d ready after done", d), upd_ready[d], 1);
    check($sformatf("dut%0d busy after done", d), busy[d], 0);
    model_update(d, vin, err, sh, exp_ovf);
    check($sformatf("dut%0d ovf pulse seen", d), ovf_seen, exp_ovf);
    msticky[d] = clr_mode ? exp_ovf : (msticky[d] | exp_ovf);
    check($sformatf("dut%0d ovf_sticky", d), ovf_sticky[d], msticky[d]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl [8];
    longint      v;
    bit          ovs;
    bit          dummy;
    logic [63:0] vin;
    int          c, first, second;
    logic        ready_at;

    tbl[0] = '{0, 10, -3, 1, 1, 8, 1'b0};
    tbl[1] = '{0, 0, -1, 1, 15, -1, 1'b0};
    tbl[2] = '{0, 32760, 127, 127, 0, 32767, 1'b1};
    tbl[3] = '{0, -32768, -128, 127, 0, -32768, 1'b1};
    tbl[4] = '{0, 100, -128, -128, 3, 2148, 1'b0};
    tbl[5] = '{0, 5, 7, -3, 2, -1, 1'b0};
    tbl[6] = '{0, -32768, 0, 5, 0, -32768, 1'b0};
    tbl[7] = '{1, 32760, 127, 127, 0, -16647, 1'b1};

    reset    = 1'b0;
    upd_in_a = '0;
    upd_in_b = '0;
    for (int d = 0; d < NT; d++) begin
      upd_valid[d] = 1'b0;
      upd_error[d] = '0;
      upd_shift[d] = '0;
      wr_en[d]     = 1'b0;
      wr_idx[d]    = '0;
      wr_data[d]   = '0;
      rd_idx[d]    = '0;
      clr_ovf[d]   = 1'b0;
    end

    // Reset state.
    do_reset();
    check("reset upd_ready", upd_ready[0], 1);
    check("reset busy", busy[0], 0);
    check("reset done", done[0], 0);
    check("reset ovf", ovf[0], 0);
    check("reset ovf_sticky", ovf_sticky[0], 0);
    check_all(0, "reset");

    // Uniform update: 3*4 >>> 2 = 3 into every weight.
    run_upd(0, {8{8'd3}}, 4, 2, 1'b0, 0, 0, 1'b0, ovs);
    check_all(0, "uniform");

    // Held upd_valid, write during CALC, then reset mid-CALC.
    do_reset();
    upd_in_a     = {8{8'd1}};
    upd_error[0] = 8'd1;
    upd_shift[0] = 4'd0;
    upd_valid[0] = 1'b1;
    tick();
    c = 1;
    check("calc upd_ready", upd_ready[0], 0);
    check("calc busy", busy[0], 1);
    wr_en[0]   = 1'b1;
    wr_idx[0]  = 3'd3;
    wr_data[0] = 16'h0055;
    tick();
    c = 2;
    wr_en[0] = 1'b0;
    first    = -1;
    second   = -1;
    ready_at = 1'b0;
    while (second < 0 && c < 40) begin
      if (c == 6) ready_at = upd_ready[0];
      if (done[0]) begin
        if (first < 0) first = c;
        else second = c;
      end
      if (second < 0) begin
        tick();
        c++;
      end
    end
    upd_valid[0] = 1'b0;
    tick();
    check("held valid first done cycle", first, 5);
    check("held valid ready in idle", ready_at, 1);
    check("held valid second done cycle", second, 11);
    model_update(0, {8{8'd1}}, 1, 0, dummy);
    model_update(0, {8{8'd1}}, 1, 0, dummy);
    check_all(0, "held valid");

    upd_in_a     = {8{8'd5}};
    upd_error[0] = 8'd3;
    upd_valid[0] = 1'b1;
    tick();
    upd_valid[0] = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midcalc reset upd_ready", upd_ready[0], 1);
    check("midcalc reset busy", busy[0], 0);
    for (int d = 0; d < NT; d++) begin
      msticky[d] = 1'b0;
      for (int i = 0; i < 8; i++) mw[d][i] = 0;
    end
    check_all(0, "midcalc reset");

    // Single-weight arithmetic vectors.
    for (int t = 0; t < 8; t++) begin
      load(tbl[t].dut, 0, tbl[t].w0);
      vin      = '0;
      vin[7:0] = 8'(tbl[t].x0);
      run_upd(tbl[t].dut, vin, tbl[t].err, tbl[t].sh, 1'b0, 0, 0, 1'b0, ovs);
      read_w(tbl[t].dut, 0, v);
      check($sformatf("vec%0d w0", t), v, tbl[t].exp_w0);
      check($sformatf("vec%0d ovf", t), ovs, tbl[t].exp_ovf);
    end

    // Partial last group with clear colliding with a new overflow.
    check("dut1 sticky before clr test", ovf_sticky[1], 1);
    load(1, 4, 32760);
    load(1, 6, 999);
    vin        = '0;
    vin[39:32] = 8'd127;
    vin[7:0]   = 8'd2;
    run_upd(1, vin, 127, 0, 1'b0, 0, 0, 1'b1, ovs);
    read_w(1, 4, v);
    check("partial group w4 wrap", v, -16647);
    check("clr vs set sticky", ovf_sticky[1], 1);
    check_all(1, "partial group");
    clr_ovf[1] = 1'b1;
    tick();
    clr_ovf[1] = 1'b0;
    check("clr_ovf clears sticky", ovf_sticky[1], 0);
    msticky[1] = 1'b0;

    // Read collides with write to the same index.
    load(0, 2, 777);
    rd_idx[0]  = 3'd2;
    wr_en[0]   = 1'b1;
    wr_idx[0]  = 3'd2;
    wr_data[0] = 16'd1234;
    tick();
    wr_en[0] = 1'b0;
    check("read during write old value", longint'($signed(rd_data[0])), 777);
    tick();
    check("read after write new value", longint'($signed(rd_data[0])), 1234);
    mw[0][2] = 1234;

    // Write and accept in the same cycle: update sees written value.
    vin        = '0;
    vin[15:8]  = 8'd2;
    run_upd(0, vin, 3, 0, 1'b1, 1, 100, 1'b0, ovs);
    read_w(0, 1, v);
    check("write then update w1", v, 106);

    // Randomized updates against the model.
    for (int r = 0; r < 25; r++) begin
      for (int d = 0; d < NT; d++) begin
        if ($urandom_range(0, 2) == 0)
          load(d, int'($urandom_range(0, 7)), int'($urandom_range(0, 65535)) - 32768);
        vin = {$urandom, $urandom};
        run_upd(d, vin, int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 15)),
                1'b0, 0, 0, ($urandom_range(0, 4) == 0), ovs);
        check_all(d, $sformatf("random%0d", r));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/slp_weight_update_seq.md
Name: slp_weight_update_seq

Overview:
Sequential weight-update engine for a single-layer perceptron neuron. It holds N_IN signed integer weights in internal registers. Each accepted update applies w[i] <= w[i] + ((in[i]*error) >>> rate_shift), processing LANES weights per cycle. It replaces per-weight combinational update logic with a shared, multi-lane datapath that has a runtime learning-rate shift, selectable saturate/wrap, and a sticky overflow flag. It sits between the error calculator and the neuron's forward-path weight reads.

Parameters:
N_IN, 8, number of inputs/weights per neuron (>=1)
LANES, 2, weights updated per cycle (1..N_IN)
I_PREC, 8, input element width, signed two's complement, frac 0
P_PREC, 8, error width, signed, frac 0
W_PREC, 16, weight width, signed, frac 0
SHIFT_W, 4, width of rate_shift
SAT, 1, 1 = saturate the weight on overflow, 0 = wrap (keep low W_PREC bits)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
upd_valid  in  1  update request
upd_ready  out  1  high only in IDLE
upd_in  in  N_IN*I_PREC  input vector, element i at [i*I_PREC +: I_PREC]
upd_error  in  P_PREC  error term
upd_shift  in  SHIFT_W  learning-rate right shift
done  out  1  one-cycle pulse when all weights are updated
busy  out  1  high in CALC and DONE
wr_en  in  1  direct weight load (honoured only in IDLE)
wr_idx  in  $clog2(N_IN) (min 1)  load index
wr_data  in  W_PREC  load value
rd_idx  in  $clog2(N_IN) (min 1)  read index
rd_data  out  W_PREC  registered weight read
ovf  out  1  one-cycle pulse if any lane overflowed in that CALC cycle
ovf_sticky  out  1  latched OR of ovf
clr_ovf  in  1  clears ovf_sticky

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: all weights 0, state IDLE, upd_ready=1, busy=0, done=0, ovf=0, ovf_sticky=0, rd_data=0, group counter 0.
- Reset asserted mid-CALC aborts the update; all weights return to 0.
- FSM states: IDLE -> CALC on upd_valid&&upd_ready; CALC -> DONE after K=ceil(N_IN/LANES) cycles; DONE -> IDLE after 1 cycle.
- Accept cycle: upd_in, upd_error and upd_shift are latched. Later input changes have no effect.
- Latency: accept at cycle T. Group g (weights g*LANES .. g*LANES+LANES-1) is written at the clock edge ending cycle T+1+g. done=1 during cycle T+K+1. upd_ready returns high at T+K+2.
- Partial last group: lanes with index >= N_IN are inactive, never write, and never flag ovf.
- Arithmetic per lane:
  - prod = signed(in[i]) * signed(error), width I_PREC+P_PREC, exact.
  - delta = prod >>> upd_shift (arithmetic, rounds toward -inf). A shift >= I_PREC+P_PREC gives 0 or -1 by sign.
  - sum = sext(w) + sext(delta), width max(W_PREC, I_PREC+P_PREC)+1, exact.
  - Overflow when sum is outside [-2^(W_PREC-1), 2^(W_PREC-1)-1].
  - SAT=1 clamps to that range; SAT=0 takes sum[W_PREC-1:0].
- ovf is registered and pulses the cycle after the overflowing group's write.
- ovf_sticky sets on ovf. clr_ovf clears it; if set and clear fall in the same cycle, set wins.
- wr_en:
  - Writes at the edge if the state is IDLE; ignored in CALC/DONE.
  - wr_en together with an accepted upd_valid: the write commits first, so the update sees the written value.
  - Out-of-range wr_idx (>= N_IN) is ignored.
- rd_data = w[rd_idx] registered with 1-cycle latency, readable in any state. It shows the pre-write value when the read coincides with a write to the same index. An out-of-range rd_idx returns 0.
- upd_valid while not ready is not accepted; the requester holds it.

Test Plan:
1. Reset, then read idx 0..7 -> rd_data=0 for each; upd_ready=1, busy=0, ovf_sticky=0.
2. Weights 0, all in=3, error=4, shift=2, accept at T -> done at T+5; every weight reads 3; ovf never set.
3. Load w[0]=10 via wr_en; in[0]=-3, error=1, shift=1 -> delta=-2; w[0]=8. Shift=15 with in[0]=-1, error=1 -> delta=-1.
4. Load w[0]=32760; in[0]=127, error=127, shift=0 -> SAT=1: w[0]=32767, ovf pulse, ovf_sticky=1. SAT=0 build: w[0]=-16647.
5. During CALC: upd_valid held -> not accepted until upd_ready; wr_en to idx 3 with 0x55 -> ignored; reset mid-CALC -> all weights 0, IDLE the next cycle.
6. N_IN=5, LANES=2: K=3, done at T+4; lane 1 of group 2 idle. clr_ovf asserted in the same cycle as a new ovf -> ovf_sticky stays 1.
